// File: rtl/arm_mem_pkg.sv
// Shared types for the instruction/data SRAM arbiter.
package arm_mem_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Fetch port, data port and external SRAM bus of the arbiter.
interface sram_arbiter_if import arm_mem_pkg::*; #(
    parameter int unsigned SRAM_AW = 18
) ();

    logic              if_req;
    logic [31:0]       if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_freeze;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_freeze;

    logic               sram_en;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wdata;
    logic [DATA_W-1:0]  sram_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, if_freeze, mem_rdata, mem_ready, mem_freeze,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    // Pipeline and SRAM side.
    modport master (
        output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, if_freeze, mem_rdata, mem_ready, mem_freeze,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: loads WAIT_CYCLES, counts to zero and holds there.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= 4'(WAIT_CYCLES);
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Single-ported SRAM shared by fetch and data stages; data wins ties and
// every access takes WAIT_CYCLES+1 SRAM cycles followed by a one-cycle report.
module sram_arbiter import arm_mem_pkg::*; #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_arbiter_if.slave        bus
);

    state_e            state_q;
    owner_e            owner_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_ready_q;
    logic              if_pend_q;
    logic              sram_en_q;
    logic              sram_we_q;

    logic data_req;
    logic cnt_load;
    logic cnt_zero;

    assign data_req = bus.mem_rd_en | bus.mem_wr_en;
    assign cnt_load = (state_q == IDLE) & (data_req | bus.if_req);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (state_q == ACCESS),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
            if_pend_q   <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            if_pend_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_req) begin
                        owner_q   <= OWN_DATA;
                        addr_q    <= bus.mem_addr;
                        wdata_q   <= bus.mem_wdata;
                        sram_en_q <= 1'b1;
                        sram_we_q <= bus.mem_wr_en;
                        state_q   <= ACCESS;
                    end else if (bus.if_req) begin
                        owner_q   <= OWN_FETCH;
                        addr_q    <= bus.if_addr;
                        sram_en_q <= 1'b1;
                        sram_we_q <= 1'b0;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (owner_q == OWN_DATA) begin
                            mem_rdata_q <= bus.sram_rdata;
                            mem_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.sram_rdata;
                            if_pend_q  <= 1'b1;
                        end
                        sram_en_q <= 1'b0;
                        sram_we_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = addr_q[SRAM_AW+1:2];
    assign bus.sram_wdata = wdata_q;

    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    // A fetch whose PC moved on (or whose request dropped) is silently discarded.
    assign bus.if_ready  = if_pend_q & bus.if_req & (bus.if_addr == addr_q);

    assign bus.if_freeze  = bus.if_req & ~bus.if_ready;
    assign bus.mem_freeze = data_req & ~bus.mem_ready;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: one arbiter with 3 wait states, one with none, sharing a word-array SRAM model.
module tb_sram_arbiter;
    import arm_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.SRAM_AW(18)) bus3 ();
    sram_arbiter_if #(.SRAM_AW(18)) bus0 ();

    sram_arbiter #(.WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    sram_arbiter #(.WAIT_CYCLES(0), .SRAM_AW(18)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus3.sram_en && bus3.sram_we) mem[bus3.sram_addr[9:0]] <= bus3.sram_wdata;
    end

    assign bus3.sram_rdata = mem[bus3.sram_addr[9:0]];
    assign bus0.sram_rdata = mem[bus0.sram_addr[9:0]];

    int tests = 0;
    int fails = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.mem_rd_en = 1'b0; bus3.mem_wr_en = 1'b0;
        bus3.mem_addr = '0; bus3.mem_wdata = '0;
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.mem_rd_en = 1'b0; bus0.mem_wr_en = 1'b0;
        bus0.mem_addr = '0; bus0.mem_wdata = '0;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    // Leaves the bench at the start of an IDLE cycle ("cycle 0").
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++; if (bus3.sram_en !== 1'b0) begin fails++; $display("FAIL reset_sram_en got=%0b exp=0", bus3.sram_en); end
        tests++; if (bus3.if_ready !== 1'b0) begin fails++; $display("FAIL reset_if_ready got=%0b exp=0", bus3.if_ready); end
        tests++; if (bus3.mem_ready !== 1'b0) begin fails++; $display("FAIL reset_mem_ready got=%0b exp=0", bus3.mem_ready); end
        tests++; if (bus3.if_rdata !== 32'h0) begin fails++; $display("FAIL reset_if_rdata got=%h exp=0", bus3.if_rdata); end
        tests++; if (bus3.mem_rdata !== 32'h0) begin fails++; $display("FAIL reset_mem_rdata got=%h exp=0", bus3.mem_rdata); end
        tests++; if (bus3.sram_addr !== 18'h0) begin fails++; $display("FAIL reset_sram_addr got=%h exp=0", bus3.sram_addr); end
        tests++; if (bus0.sram_en !== 1'b0) begin fails++; $display("FAIL reset0_sram_en got=%0b exp=0", bus0.sram_en); end
        tests++; if (dut3.state_q !== IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", dut3.state_q, IDLE); end
        next_cycle();
    endtask

    task automatic test_single_fetch();
        logic exp_en;
        load(10'h4, 32'hE3A0_1005);
        do_reset();
        bus3.if_req = 1'b1; bus3.if_addr = 32'h10;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_en = (c >= 1 && c <= 4);
            tests++; if (bus3.sram_en !== exp_en) begin fails++; $display("FAIL single_en c=%0d got=%0b exp=%0b", c, bus3.sram_en, exp_en); end
            if (exp_en) begin
                tests++; if (bus3.sram_addr !== 18'h4) begin fails++; $display("FAIL single_addr c=%0d got=%h exp=4", c, bus3.sram_addr); end
            end
            tests++; if (bus3.if_ready !== (c == 5)) begin fails++; $display("FAIL single_ready c=%0d got=%0b exp=%0b", c, bus3.if_ready, (c == 5)); end
            tests++; if (bus3.if_freeze !== (c <= 4)) begin fails++; $display("FAIL single_freeze c=%0d got=%0b exp=%0b", c, bus3.if_freeze, (c <= 4)); end
            if (c == 5) begin
                tests++; if (bus3.if_rdata !== 32'hE3A0_1005) begin fails++; $display("FAIL single_rdata got=%h exp=e3a01005", bus3.if_rdata); end
            end
            next_cycle();
        end
        bus3.if_req = 1'b0;
        @(negedge clk);
        tests++; if (bus3.if_rdata !== 32'hE3A0_1005) begin fails++; $display("FAIL single_hold got=%h exp=e3a01005", bus3.if_rdata); end
    endtask

    task automatic test_simultaneous();
        load(10'h40, 32'h1122_3344);
        do_reset();
        bus3.if_req = 1'b1; bus3.if_addr = 32'h10;
        bus3.mem_rd_en = 1'b1; bus3.mem_addr = 32'h100;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            tests++; if (bus3.mem_ready !== (c == 5)) begin fails++; $display("FAIL simul_mem_ready c=%0d got=%0b exp=%0b", c, bus3.mem_ready, (c == 5)); end
            tests++; if (bus3.if_ready !== (c == 11)) begin fails++; $display("FAIL simul_if_ready c=%0d got=%0b exp=%0b", c, bus3.if_ready, (c == 11)); end
            if (c == 1) begin
                tests++; if (bus3.sram_addr !== 18'h40) begin fails++; $display("FAIL simul_data_addr got=%h exp=40", bus3.sram_addr); end
            end
            if (c == 5) begin
                tests++; if (bus3.mem_rdata !== 32'h1122_3344) begin fails++; $display("FAIL simul_mem_rdata got=%h exp=11223344", bus3.mem_rdata); end
            end
            if (c == 6) begin
                tests++; if (bus3.sram_en !== 1'b0) begin fails++; $display("FAIL simul_idle_en got=%0b exp=0", bus3.sram_en); end
            end
            if (c == 7) begin
                tests++; if (bus3.sram_en !== 1'b1 || bus3.sram_addr !== 18'h4) begin fails++; $display("FAIL simul_fetch_start en=%0b addr=%h exp en=1 addr=4", bus3.sram_en, bus3.sram_addr); end
            end
            if (c == 11) begin
                tests++; if (bus3.if_rdata !== 32'hE3A0_1005) begin fails++; $display("FAIL simul_if_rdata got=%h exp=e3a01005", bus3.if_rdata); end
            end
            next_cycle();
            if (c == 5) bus3.mem_rd_en = 1'b0;
        end
        bus3.if_req = 1'b0;
    endtask

    task automatic test_write_read();
        int we_cnt;
        do_reset();
        we_cnt = 0;
        bus3.mem_wr_en = 1'b1; bus3.mem_addr = 32'h200; bus3.mem_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (bus3.sram_we) begin
                we_cnt++;
                tests++; if (bus3.sram_addr !== 18'h80) begin fails++; $display("FAIL wr_addr c=%0d got=%h exp=80", c, bus3.sram_addr); end
            end
            if (c == 5) begin
                tests++; if (bus3.mem_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got=%0b exp=1", bus3.mem_ready); end
            end
            next_cycle();
        end
        bus3.mem_wr_en = 1'b0;
        tests++; if (we_cnt != 4) begin fails++; $display("FAIL wr_we_cycles got=%0d exp=4", we_cnt); end
        bus3.mem_rd_en = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            tests++; if (bus3.mem_ready !== (c == 5)) begin fails++; $display("FAIL rd_ready c=%0d got=%0b exp=%0b", c, bus3.mem_ready, (c == 5)); end
            if (c == 5) begin
                tests++; if (bus3.mem_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus3.mem_rdata); end
            end
            next_cycle();
        end
        bus3.mem_rd_en = 1'b0;
    endtask

    task automatic test_stale_fetch();
        load(10'h8, 32'hAAAA_0008);
        load(10'h10, 32'h5555_0010);
        do_reset();
        bus3.if_req = 1'b1; bus3.if_addr = 32'h20;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            tests++; if (bus3.if_ready !== (c == 11)) begin fails++; $display("FAIL stale_ready c=%0d got=%0b exp=%0b", c, bus3.if_ready, (c == 11)); end
            if (c == 1) begin
                tests++; if (bus3.sram_addr !== 18'h8) begin fails++; $display("FAIL stale_first_addr got=%h exp=8", bus3.sram_addr); end
            end
            if (c == 5) begin
                tests++; if (bus3.if_freeze !== 1'b1) begin fails++; $display("FAIL stale_freeze got=%0b exp=1", bus3.if_freeze); end
            end
            if (c == 7) begin
                tests++; if (bus3.sram_addr !== 18'h10) begin fails++; $display("FAIL stale_new_addr got=%h exp=10", bus3.sram_addr); end
            end
            if (c == 11) begin
                tests++; if (bus3.if_rdata !== 32'h5555_0010) begin fails++; $display("FAIL stale_rdata got=%h exp=55550010", bus3.if_rdata); end
            end
            next_cycle();
            if (c == 1) bus3.if_addr = 32'h40;
        end
        bus3.if_req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        bus3.if_req = 1'b1; bus3.if_addr = 32'h10;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) begin
                tests++; if (bus3.if_ready !== 1'b1) begin fails++; $display("FAIL rstmid_pre_ready got=%0b exp=1", bus3.if_ready); end
            end
            if (c == 7) begin
                tests++; if (bus3.sram_en !== 1'b1) begin fails++; $display("FAIL rstmid_second_en got=%0b exp=1", bus3.sram_en); end
            end
            next_cycle();
            if (c == 7) begin
                rst = 1'b1;
                bus3.if_req = 1'b0;
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus3.sram_en !== 1'b0) begin fails++; $display("FAIL rstmid_en got=%0b exp=0", bus3.sram_en); end
        tests++; if (bus3.if_ready !== 1'b0 || bus3.mem_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got=%0b/%0b exp=0/0", bus3.if_ready, bus3.mem_ready); end
        tests++; if (bus3.if_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_if_rdata got=%h exp=0", bus3.if_rdata); end
        tests++; if (bus3.mem_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_mem_rdata got=%h exp=0", bus3.mem_rdata); end
        tests++; if (dut3.state_q !== IDLE) begin fails++; $display("FAIL rstmid_state got=%0d exp=%0d", dut3.state_q, IDLE); end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clk);
            tests++; if ((bus3.if_ready | bus3.mem_ready) !== 1'b0) begin fails++; $display("FAIL rstmid_no_ready c=%0d got=%0b exp=0", c, bus3.if_ready | bus3.mem_ready); end
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic        exp_rdy;
        logic [31:0] exp_data;
        load(10'h0, 32'h1000_0000);
        load(10'h1, 32'h1000_0004);
        load(10'h2, 32'h1000_0008);
        do_reset();
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            exp_rdy  = (c == 2 || c == 5 || c == 8);
            exp_data = 32'h1000_0000 | 32'((c / 3) * 4);
            tests++; if (bus0.if_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready c=%0d got=%0b exp=%0b", c, bus0.if_ready, exp_rdy); end
            if (exp_rdy) begin
                tests++; if (bus0.if_rdata !== exp_data) begin fails++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, bus0.if_rdata, exp_data); end
            end
            if (c == 1 || c == 3) begin
                tests++; if (bus0.sram_en !== (c == 1)) begin fails++; $display("FAIL b2b_en c=%0d got=%0b exp=%0b", c, bus0.sram_en, (c == 1)); end
            end
            next_cycle();
            if (c == 2) bus0.if_addr = 32'h4;
            if (c == 5) bus0.if_addr = 32'h8;
        end
        bus0.if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write_read();
        test_stale_fetch();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-ported, word-wide external SRAM between the instruction-fetch stage and the memory stage of the ARM pipeline. Each access takes a fixed number of wait states, and the block sequences it. It returns read data and drives per-port freeze outputs, which the pipeline ORs into its existing stage freeze/hazard logic. Data accesses have priority over fetches.

## Interface
- WAIT_CYCLES, 3: extra SRAM cycles per access; legal range 0–15.
- SRAM_AW, 18: SRAM word-address width; word address = byte address[SRAM_AW+1:2].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch port requests the word at if_addr.
- if_addr  in  32  fetch byte address (the PC).
- if_rdata  out  32  fetched instruction, valid while if_ready.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- if_freeze  out  1  if_req & ~if_ready.
- mem_rd_en  in  1  data read request.
- mem_wr_en  in  1  data write request; never asserted together with mem_rd_en.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data, valid while mem_ready.
- mem_ready  out  1  one-cycle completion pulse for the data port.
- mem_freeze  out  1  (mem_rd_en|mem_wr_en) & ~mem_ready.
- sram_en  out  1  SRAM access active.
- sram_we  out  1  write strobe.
- sram_addr  out  SRAM_AW  word address.
- sram_wdata  out  32  write data to the SRAM.
- sram_rdata  in  32  read data from the SRAM; valid by the final access cycle.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: drive the SRAM.
  - DONE: report the result.
- IDLE transitions:
  - If a data request is present, latch the owner as DATA plus the address, write data and read/write type, then go to ACCESS.
  - Otherwise, if if_req is high, latch the owner as FETCH plus if_addr, then go to ACCESS.
  - Otherwise, stay in IDLE.
- ACCESS:
  - sram_en=1. sram_addr and sram_wdata come from the latched values; sram_we=1 for the whole state if the access is a write.
  - A wait counter loads WAIT_CYCLES on entry and counts down.
  - When the counter is 0, capture sram_rdata into the owner's rdata register and go to DONE.
- DONE:
  - sram_en=0, sram_we=0.
  - Owner DATA: assert mem_ready, then go to IDLE.
  - Owner FETCH: assert if_ready only if if_req=1 and if_addr equals the latched address. Otherwise the fetch is stale (branch redirected the PC or the request was dropped): no ready, result discarded. Either way, go to IDLE.
- An ACCESS in progress always completes; request changes during ACCESS are ignored.
- The data port holds its inputs stable until mem_ready; its DONE result is never discarded.
- if_rdata and mem_rdata hold their last captured value until the next capture.
- Reset from any state returns to IDLE. All outputs, both rdata registers and the wait counter go to 0; an in-flight access is abandoned with no ready pulse.

## Timing
- A request seen in IDLE in cycle t produces:
  - SRAM driven in cycles t+1 … t+1+WAIT_CYCLES;
  - ready in cycle t+2+WAIT_CYCLES;
  - IDLE again in cycle t+3+WAIT_CYCLES.
- Throughput is one access per WAIT_CYCLES+3 cycles.
- With WAIT_CYCLES=0: SRAM driven in t+1, ready in t+2.
- ready is a single-cycle pulse. Freeze drops in that same cycle, so the stage registers capture rdata on that edge.
- Fetch and data requests arriving in the same IDLE cycle: data wins. The fetch waits and is granted in the next IDLE if still requested.
- The stale-fetch check in DONE is a combinational compare on the current if_addr.

## Structure
- Package arm_mem_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - owner enum {OWN_FETCH, OWN_DATA};
  - DATA_W=32.
- Sub-module sram_wait_counter: 4-bit down-counter with load and zero flag, parameterised by WAIT_CYCLES.
- Freeze outputs are continuous assigns. Everything else is registered.

## Test plan
- Single fetch: WAIT_CYCLES=3, if_req=1 with if_addr=0x10 at cycle 0, SRAM word 4 = 0xE3A01005. Required: sram_en=1 in cycles 1–4 with sram_addr=4; if_ready=1 and if_rdata=0xE3A01005 in cycle 5; if_freeze=1 in cycles 0–4.
- Simultaneous requests: if_req and mem_rd_en asserted together in cycle 0, mem_addr=0x100. Required: data is served first with mem_ready in cycle 5. The fetch begins ACCESS in cycle 7, with if_ready in cycle 11.
- Write then read: write 0xDEADBEEF to 0x200, then read 0x200. Required: sram_we=1 for exactly 4 cycles at sram_addr=0x80; the read returns 0xDEADBEEF.
- Stale fetch: fetch of 0x20 starts, and if_addr changes to 0x40 during ACCESS. Required: no if_ready in DONE. A new access to word 0x10 follows, with if_ready for that access.
- Reset mid-access: assert rst during the second ACCESS cycle. Required: the next cycle has sram_en=0, both ready=0, both rdata=0, and the FSM in IDLE. No ready pulse follows.
- WAIT_CYCLES=0 back-to-back fetches of 0x0, 0x4, 0x8. Required: if_ready in cycles 2, 5 and 8 with the correct data.
